// File: rtl/gray_counter_if.sv
// Control/status bundle between a Gray counter and whatever steers it.
// master drives count/load controls; slave returns the registered Gray count and pulses.
interface gray_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_gray_no;
   logic [WIDTH-1:0] gray_no;
   logic             step;
   logic             wrap;

   modport master (
      output en, up, load, load_gray_no,
      input  gray_no, step, wrap
   );

   modport slave (
      input  en, up, load, load_gray_no,
      output gray_no, step, wrap
   );
endinterface

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with a binary shadow count.
// Every output is a flop, so the Gray value is glitch-free for downstream conversion.
module gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   gray_counter_if.slave  bus
);

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;

   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] cnt_bin;

   // Each binary bit is the parity of the Gray bits at and above it; no ripple chain.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
         assign load_bin[gi] = ^bus.load_gray_no[WIDTH-1:gi];
      end
   endgenerate

   assign cnt_bin = bus.up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);

   always_comb begin
      bin_d  = bin_q;
      gray_d = gray_q;
      step_d = 1'b0;
      wrap_d = 1'b0;
      if (bus.load) begin
         bin_d  = load_bin;
         gray_d = bus.load_gray_no;
      end else if (bus.en) begin
         bin_d  = cnt_bin;
         gray_d = cnt_bin ^ (cnt_bin >> 1);
         step_d = 1'b1;
         wrap_d = bus.up ? (bin_q == '1) : (bin_q == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.gray_no = gray_q;
   assign bus.step    = step_q;
   assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter at WIDTH=4 and WIDTH=7 driven by shared stimulus.
// Expected responses are queued at issue time and popped by an independent monitor.
module tb_gray_counter;

   typedef struct {
      int gray;
      int bin;
      bit step;
      bit wrap;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   exp_t q_exp[2][$];
   int   m_bin[2];
   int   prev_gray[2];
   bit   prev_valid[2];

   gray_counter_if #(.WIDTH(4)) bus4 ();
   gray_counter_if #(.WIDTH(7)) bus7 ();

   gray_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   gray_counter #(.WIDTH(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

   always #5 clk = ~clk;

   function automatic int wid(input int k);
      return (k == 0) ? 4 : 7;
   endfunction

   // Reference decode by search: the binary count whose Gray image is g.
   function automatic int gray_to_bin(input int g, input int w);
      for (int b = 0; b < (1 << w); b++)
         if ((b ^ (b >> 1)) == g) return b;
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Drive one clock's worth of inputs, queue the model's response, advance to the next negedge.
   task automatic apply(input bit r, input bit e, input bit u, input bit l, input int lg);
      rst               = r;
      bus4.en           = e;
      bus4.up           = u;
      bus4.load         = l;
      bus4.load_gray_no = 4'(lg);
      bus7.en           = e;
      bus7.up           = u;
      bus7.load         = l;
      bus7.load_gray_no = 7'(lg);
      for (int k = 0; k < 2; k++) begin
         int   n;
         exp_t x;
         n = 1 << wid(k);
         x.step = 1'b0;
         x.wrap = 1'b0;
         if (r) begin
            m_bin[k] = 0;
         end else if (l) begin
            m_bin[k] = gray_to_bin(lg % n, wid(k));
         end else if (e) begin
            x.step = 1'b1;
            if (u) begin
               x.wrap   = (m_bin[k] == n - 1);
               m_bin[k] = (m_bin[k] + 1) % n;
            end else begin
               x.wrap   = (m_bin[k] == 0);
               m_bin[k] = (m_bin[k] + n - 1) % n;
            end
         end
         x.bin  = m_bin[k];
         x.gray = m_bin[k] ^ (m_bin[k] >> 1);
         q_exp[k].push_back(x);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_out(input int k, input int g, input bit s, input bit w);
      exp_t  x;
      string tag;
      x   = q_exp[k].pop_front();
      tag = (k == 0) ? "w4" : "w7";
      chk({tag, "_gray"}, g, x.gray);
      chk({tag, "_step"}, int'(s), int'(x.step));
      chk({tag, "_wrap"}, int'(w), int'(x.wrap));
      chk({tag, "_decoded_bin"}, gray_to_bin(g, wid(k)), x.bin);
      if (x.step && prev_valid[k])
         chk({tag, "_step_hamming"}, $countones(g ^ prev_gray[k]), 1);
      prev_gray[k]  = g;
      prev_valid[k] = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (q_exp[0].size() > 0)
         check_out(0, int'(bus4.gray_no), bus4.step, bus4.wrap);
      if (q_exp[1].size() > 0)
         check_out(1, int'(bus7.gray_no), bus7.step, bus7.wrap);
   end

   initial begin
      m_bin[0] = 0;
      m_bin[1] = 0;
      prev_valid[0] = 1'b0;
      prev_valid[1] = 1'b0;

      // Reset then a full up sweep for the 4-bit counter.
      apply(1, 0, 0, 0, 0);
      apply(1, 1, 1, 1, 5);
      chk("reset_gray", int'(bus4.gray_no), 0);
      chk("reset_step", int'(bus4.step), 0);
      for (int i = 0; i < 16; i++) apply(0, 1, 1, 0, 0);
      chk("sweep_end_gray", int'(bus4.gray_no), 0);
      chk("sweep_end_wrap", int'(bus4.wrap), 1);

      // Down-wrap from reset, then hold.
      apply(1, 0, 0, 0, 0);
      apply(0, 1, 0, 0, 0);
      chk("down_wrap_gray", int'(bus4.gray_no), 4'b1000);
      chk("down_wrap_wrap", int'(bus4.wrap), 1);
      apply(0, 0, 0, 0, 0);
      chk("hold_gray", int'(bus4.gray_no), 4'b1000);
      chk("hold_step", int'(bus4.step), 0);

      // Load then increment.
      apply(0, 0, 0, 1, 4'b0110);
      chk("load_gray", int'(bus4.gray_no), 4'b0110);
      apply(0, 1, 1, 0, 0);
      chk("load_inc_gray", int'(bus4.gray_no), 4'b0111);

      // Load beats en in the same cycle.
      apply(0, 1, 1, 1, 4'b1010);
      chk("load_wins_gray", int'(bus4.gray_no), 4'b1010);
      chk("load_wins_step", int'(bus4.step), 0);

      // Reset mid-count with en held high.
      apply(1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) apply(0, 1, 1, 0, 0);
      chk("pre_rst_gray", int'(bus4.gray_no), 4'b1101);
      apply(1, 1, 1, 0, 0);
      chk("mid_rst_gray", int'(bus4.gray_no), 0);
      apply(0, 1, 1, 0, 0);
      chk("post_rst_gray", int'(bus4.gray_no), 4'b0001);

      // Random en/up/load/rst mix, both widths.
      for (int i = 0; i < 1000; i++) begin
         bit r, e, u, l;
         r = ($urandom_range(63) == 0);
         l = ($urandom_range(7) == 0);
         e = ($urandom_range(3) != 0);
         u = $urandom_range(1);
         apply(r, e, u, l, int'($urandom_range(127)));
      end

      apply(0, 0, 0, 0, 0);
      chk("queue_drained_w4", q_exp[0].size(), 0);
      chk("queue_drained_w7", q_exp[1].size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
